wb_burst_sram: RTL and testbench
================================

# wb_burst_sram

Wishbone B4 pipelined-free (classic + registered-feedback burst) SRAM responder that sits at the far end of the benchmark's Wishbone bus as the target of the cocotb initiator. It serves classic single cycles and CTI/BTE incrementing bursts from an internal word-addressed memory. Burst reads stream at one beat per clock after a single-cycle initial latency. Out-of-range accesses are answered with `err`.

## Interface
- `AW`, 10: word-address width of the memory (depth 2^AW words of 32 bits).
- `INIT_FILE`, "": optional `$readmemh` image; empty means contents undefined at start.

Ports:
- `clock` in 1: system clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `io_wbs_adr` in 30: word address.
- `io_wbs_datwr` in 32: write data.
- `io_wbs_datrd` out 32: read data, valid when `io_wbs_ack`.
- `io_wbs_sel` in 4: byte enables, bit i covers bits 8i+7:8i.
- `io_wbs_we` in 1: write enable.
- `io_wbs_stb` in 1: strobe.
- `io_wbs_cyc` in 1: bus cycle.
- `io_wbs_cti` in 3: cycle type; 000 classic, 010 incrementing burst, 111 end of burst, all others treated as classic.
- `io_wbs_bte` in 2: burst type; 00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16.
- `io_wbs_ack` out 1: beat acknowledge.
- `io_wbs_err` out 1: error termination.

## Operation
- Request = `cyc & stb`. Beat completes in a cycle with request and `ack` (or `err`) high.
- In range: `adr[29:AW] == 0`. Out of range: `err` instead of `ack`, no write, `datrd` unchanged.
- Writes: on completed write beat, for each set `sel[i]`, `mem[adr][byte i] <= datwr[byte i]`. `sel == 0` acks with no change.
- Reads: `datrd` registered from `mem[adr]` in the cycle before the ack it accompanies. Holds its value when `ack` is low.
- FSM states:
  - IDLE: `ack`/`err` low. On request, register ack (or err) for next cycle, capture `we`, compute `pred = next(adr, bte)`. Next state is BURST if cti == 010 and in range, else SINGLE.
  - SINGLE: `ack`/`err` high for exactly this cycle. Next state IDLE with `ack` low, even if `stb` is still high. Classic throughput is 1 beat / 2 cycles.
  - BURST: `ack` high this cycle. Evaluate current inputs:
    - Stay in BURST (ack next cycle, read `mem[adr]`, `pred <= next(adr, bte)`) iff request, `adr == pred`, `we` equal to the captured value, cti == 010, and in range.
    - cti == 111 with other conditions met: one final ack next cycle, then IDLE (via SINGLE).
    - Any other case (stb low, cyc low, address mismatch, `we` change, out of range, other cti): `ack` low next cycle, IDLE. The request restarts with the IDLE latency.
- `next(a, bte)`: linear gives `a+1` (30-bit wrap). Wrap-N increments the low log2(N) bits modulo N and keeps the upper bits.
- `err` is never asserted together with `ack`. `err` ends any burst.
- `cyc` low in any state: next cycle `ack`=`err`=0, IDLE.

## Timing
- Reset: `io_wbs_ack`=0, `io_wbs_err`=0, `io_wbs_datrd`=0, FSM IDLE, `pred`=0. Memory is not cleared.
- Reset mid-burst: outputs 0 the cycle after the reset edge. Any write in the reset cycle is discarded.
- Classic latency: request at cycle t gives ack at t+1. `ack` is low at t+2.
- Burst of N beats (first request at t): acks at t+1 … t+N, `ack` low at t+N+1. Total N+1 cycles.
- `ack` that is high while the initiator holds `stb` low is not a beat. No write occurs and the burst ends.
- Write of address A followed by a classic read of A returns the new data; the read is always issued at least one cycle later.

## Test plan
- Classic write `0xDEADBEEF` to adr 5, sel 1111, then classic read adr 5 -> each ack is 1 cycle after `stb` and lasts 1 cycle; `datrd` = `0xDEADBEEF`.
- Write `0x11223344` sel 0101 over adr 5, then read -> `0xDE22BE44`.
- Preload mem[0x10+i] = i. 8-beat linear read burst from 0x10, cti 010×7 then 111 -> acks on 8 consecutive cycles, data 0..7, `ack` low on cycle 9.
- Wrap-4 burst from 0x0E, addresses 0E,0F,0C,0D -> data mem[0E],[0F],[0C],[0D]. The same burst with the third address 0x10 -> `ack` drops after beat 2, and the re-request acks after a 1-cycle gap.
- AW=10, classic write to adr 0x400 -> `err` pulse 1 cycle, no `ack`. mem[0] is unchanged on read-back.
- 16-beat write burst with `stb` dropped after beat 4 -> only 4 words written. A repeat with `reset` asserted at beat 6 -> `ack`=0 the next cycle and exactly 5 words written.

Source files
------------

// File: rtl/wb_burst_sram.sv
// Wishbone B4 word-addressed SRAM responder: classic cycles plus
// CTI/BTE incrementing bursts streamed at one beat per clock.
module wb_burst_sram #(
  parameter int AW        = 10,
  parameter     INIT_FILE = ""
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [29:0] io_wbs_adr,
  input  logic [31:0] io_wbs_datwr,
  output logic [31:0] io_wbs_datrd,
  input  logic [3:0]  io_wbs_sel,
  input  logic        io_wbs_we,
  input  logic        io_wbs_stb,
  input  logic        io_wbs_cyc,
  input  logic [2:0]  io_wbs_cti,
  input  logic [1:0]  io_wbs_bte,
  output logic        io_wbs_ack,
  output logic        io_wbs_err
);

  localparam int         DEPTH   = 1 << AW;
  localparam logic [2:0] CTI_INC = 3'b010;
  localparam logic [2:0] CTI_EOB = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    SINGLE,
    BURST
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   mem [DEPTH];
  logic          ack_q, err_q, we_q;
  logic [31:0]   datrd_q;
  logic [29:0]   pred_q;
  logic [AW-1:0] wadr_q;
  logic [31:0]   wdat_q;
  logic [3:0]    wsel_q;

  logic          req, in_rng, match;
  logic          take, fault, commit;
  logic [AW-1:0] idx;

  function automatic logic [29:0] next_adr(
    input logic [29:0] a,
    input logic [1:0]  bte
  );
    logic [29:0] n;
    n = a;
    unique case (bte)
      2'b00: n = a + 30'd1;
      2'b01: n[1:0] = a[1:0] + 2'd1;
      2'b10: n[2:0] = a[2:0] + 3'd1;
      2'b11: n[3:0] = a[3:0] + 4'd1;
    endcase
    return n;
  endfunction

  assign idx    = io_wbs_adr[AW-1:0];
  assign req    = io_wbs_cyc & io_wbs_stb;
  assign in_rng = (io_wbs_adr[29:AW] == '0);

  // A burst only continues on the predicted address with unchanged direction
  assign match = req & in_rng
               & (io_wbs_adr == pred_q)
               & (io_wbs_we == we_q);

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (io_wbs_cti == CTI_INC && in_rng)
            state_d = BURST;
          else
            state_d = SINGLE;
        end
      end
      SINGLE: state_d = IDLE;
      BURST: begin
        if (match && io_wbs_cti == CTI_INC)
          state_d = BURST;
        else if (match && io_wbs_cti == CTI_EOB)
          state_d = SINGLE;
        else
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    take  = 1'b0;
    fault = 1'b0;
    unique case (state_q)
      IDLE: begin
        take  = req & in_rng;
        fault = req & ~in_rng;
      end
      BURST: begin
        take = match & ((io_wbs_cti == CTI_INC) |
                        (io_wbs_cti == CTI_EOB));
      end
      default: begin
        take  = 1'b0;
        fault = 1'b0;
      end
    endcase
  end

  // Write lands in the ack cycle, only if the initiator still strobes
  assign commit = ack_q & req & we_q & ~reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      datrd_q <= '0;
      pred_q  <= '0;
    end else begin
      ack_q <= take;
      err_q <= fault;
      if (take) begin
        we_q   <= io_wbs_we;
        pred_q <= next_adr(io_wbs_adr, io_wbs_bte);
      end
      if (take && !io_wbs_we)
        datrd_q <= mem[idx];
    end
  end

  always_ff @(posedge clock) begin
    if (take) begin
      wadr_q <= idx;
      wdat_q <= io_wbs_datwr;
      wsel_q <= io_wbs_sel;
    end
  end

  always_ff @(posedge clock) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (wsel_q[i])
          mem[wadr_q][8*i +: 8] <= wdat_q[8*i +: 8];
      end
    end
  end

  assign io_wbs_datrd = datrd_q;
  assign io_wbs_ack   = ack_q;
  assign io_wbs_err   = err_q;

endmodule

// File: tb/tb_wb_burst_sram.sv
// Directed bench for wb_burst_sram: classic, burst, wrap,
// out-of-range, early strobe drop and mid-burst reset.
module tb_wb_burst_sram;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [29:0] adr;
  logic [31:0] datwr;
  logic [31:0] datrd;
  logic [3:0]  sel;
  logic        we, stb, cyc;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack, err;

  int n_assert = 0;
  int n_fail   = 0;

  logic [29:0] w4 [4] = '{30'h0E, 30'h0F, 30'h0C, 30'h0D};

  wb_burst_sram #(.AW(10)) dut (
    .clock       (clock),
    .reset       (reset),
    .io_wbs_adr  (adr),
    .io_wbs_datwr(datwr),
    .io_wbs_datrd(datrd),
    .io_wbs_sel  (sel),
    .io_wbs_we   (we),
    .io_wbs_stb  (stb),
    .io_wbs_cyc  (cyc),
    .io_wbs_cti  (cti),
    .io_wbs_bte  (bte),
    .io_wbs_ack  (ack),
    .io_wbs_err  (err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic c, input logic s,
                       input logic w, input logic [29:0] a,
                       input logic [31:0] d, input logic [3:0] sl,
                       input logic [2:0] ct, input logic [1:0] bt);
    cyc   = c;
    stb   = s;
    we    = w;
    adr   = a;
    datwr = d;
    sel   = sl;
    cti   = ct;
    bte   = bt;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 30'd0, 32'd0, 4'd0, 3'd0, 2'd0);
  endtask

  task automatic classic(input string tag, input logic w,
                         input logic [29:0] a, input logic [31:0] d,
                         input logic [3:0] sl, input logic ex_err,
                         input logic chkd, input logic [31:0] ex_dat);
    drive(1'b1, 1'b1, w, a, d, sl, 3'b000, 2'b00);
    chk({tag, ".pre"}, {31'd0, ack}, 32'd0);
    tick();
    chk({tag, ".ack"}, {31'd0, ack}, {31'd0, !ex_err});
    chk({tag, ".err"}, {31'd0, err}, {31'd0, ex_err});
    if (chkd) chk({tag, ".dat"}, datrd, ex_dat);
    tick();
    chk({tag, ".ack0"}, {31'd0, ack | err}, 32'd0);
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();
    chk("rst.ack", {31'd0, ack}, 32'd0);
    chk("rst.err", {31'd0, err}, 32'd0);
    chk("rst.dat", datrd, 32'd0);
    reset = 1'b0;

    classic("wr5", 1'b1, 30'd5, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 32'd0);
    classic("rd5", 1'b0, 30'd5, 32'd0, 4'hF, 1'b0, 1'b1, 32'hDEADBEEF);
    classic("wr5p", 1'b1, 30'd5, 32'h11223344, 4'b0101, 1'b0, 1'b0, 32'd0);
    classic("rd5p", 1'b0, 30'd5, 32'd0, 4'hF, 1'b0, 1'b1, 32'hDE22BE44);
    classic("wr5z", 1'b1, 30'd5, 32'h0, 4'b0000, 1'b0, 1'b0, 32'd0);
    classic("rd5z", 1'b0, 30'd5, 32'd0, 4'hF, 1'b0, 1'b1, 32'hDE22BE44);

    for (int i = 0; i < 8; i++)
      classic("pre10", 1'b1, 30'h10 + 30'(i), 32'(i), 4'hF,
              1'b0, 1'b0, 32'd0);
    for (int j = 0; j < 4; j++)
      classic("pre0c", 1'b1, 30'h0C + 30'(j), 32'hC0DE000C + 32'(j),
              4'hF, 1'b0, 1'b0, 32'd0);
    classic("pre0", 1'b1, 30'd0, 32'h12345678, 4'hF, 1'b0, 1'b0, 32'd0);
    for (int i = 32'h40; i < 32'h60; i++)
      classic("pre40", 1'b1, 30'(i), 32'h5EED0000 + 32'(i), 4'hF,
              1'b0, 1'b0, 32'd0);

    // 8-beat linear read burst
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b1, 1'b0, 30'h10 + 30'(k), 32'd0, 4'hF,
            (k == 7) ? 3'b111 : 3'b010, 2'b00);
      tick();
      chk($sformatf("b8.ack%0d", k), {31'd0, ack}, 32'd1);
      chk($sformatf("b8.dat%0d", k), datrd, 32'(k));
    end
    tick();
    chk("b8.end", {31'd0, ack}, 32'd0);
    idle();
    tick();

    // wrap-4 read burst 0E,0F,0C,0D
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 1'b0, w4[k], 32'd0, 4'hF,
            (k == 3) ? 3'b111 : 3'b010, 2'b01);
      tick();
      chk($sformatf("w4.ack%0d", k), {31'd0, ack}, 32'd1);
      chk($sformatf("w4.dat%0d", k), datrd, 32'hC0DE0000 + 32'(w4[k]));
    end
    tick();
    chk("w4.end", {31'd0, ack}, 32'd0);
    idle();
    tick();

    // wrap-4 broken by a non-wrapping third address
    drive(1'b1, 1'b1, 1'b0, 30'h0E, 32'd0, 4'hF, 3'b010, 2'b01);
    tick();
    chk("wb.ack0", {31'd0, ack}, 32'd1);
    chk("wb.dat0", datrd, 32'hC0DE000E);
    drive(1'b1, 1'b1, 1'b0, 30'h0F, 32'd0, 4'hF, 3'b010, 2'b01);
    tick();
    chk("wb.ack1", {31'd0, ack}, 32'd1);
    chk("wb.dat1", datrd, 32'hC0DE000F);
    drive(1'b1, 1'b1, 1'b0, 30'h10, 32'd0, 4'hF, 3'b010, 2'b01);
    tick();
    chk("wb.gap", {31'd0, ack}, 32'd0);
    chk("wb.hold", datrd, 32'hC0DE000F);
    tick();
    chk("wb.re", {31'd0, ack}, 32'd1);
    chk("wb.redat", datrd, 32'd0);
    tick();
    chk("wb.end", {31'd0, ack}, 32'd0);
    idle();
    tick();

    // out of range
    classic("errw", 1'b1, 30'h400, 32'h0BAD0BAD, 4'hF, 1'b1, 1'b1, 32'd0);
    classic("rd0", 1'b0, 30'd0, 32'd0, 4'hF, 1'b0, 1'b1, 32'h12345678);
    classic("errr", 1'b0, 30'h20000005, 32'd0, 4'hF, 1'b1, 1'b1,
            32'h12345678);

    // 16-beat write burst, strobe dropped after beat 4
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b1, 1'b1, 30'h40 + 30'(k), 32'hA5A50000 + 32'(k),
            4'hF, 3'b010, 2'b00);
      tick();
      chk($sformatf("ws.ack%0d", k), {31'd0, ack}, 32'd1);
    end
    drive(1'b1, 1'b0, 1'b1, 30'h45, 32'hA5A50005, 4'hF, 3'b010, 2'b00);
    tick();
    chk("ws.end", {31'd0, ack}, 32'd0);
    idle();
    tick();
    for (int k = 0; k < 6; k++)
      classic($sformatf("wsrd%0d", k), 1'b0, 30'h40 + 30'(k), 32'd0, 4'hF,
              1'b0, 1'b1,
              (k < 4) ? 32'hA5A50000 + 32'(k) : 32'h5EED0040 + 32'(k));

    // write burst cut by reset at beat 6
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b1, 1'b1, 30'h50 + 30'(k), 32'h7E570000 + 32'(k),
            4'hF, 3'b010, 2'b00);
      tick();
      chk($sformatf("wr.ack%0d", k), {31'd0, ack}, 32'd1);
    end
    drive(1'b1, 1'b1, 1'b1, 30'h56, 32'h7E570006, 4'hF, 3'b010, 2'b00);
    reset = 1'b1;
    tick();
    chk("wr.rack", {31'd0, ack}, 32'd0);
    chk("wr.rerr", {31'd0, err}, 32'd0);
    chk("wr.rdat", datrd, 32'd0);
    reset = 1'b0;
    idle();
    tick();
    for (int k = 0; k < 7; k++)
      classic($sformatf("wrrd%0d", k), 1'b0, 30'h50 + 30'(k), 32'd0, 4'hF,
              1'b0, 1'b1,
              (k < 5) ? 32'h7E570000 + 32'(k) : 32'h5EED0050 + 32'(k));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
